// File: rtl/m68k_region_decoder.sv
// m68k_region_decoder: registered 68000 address decoder with a runtime-loaded
// table of base/mask regions, one-hot chip selects and a DTACK generator with
// per-region wait states.
// Optional feature macro: M68K_BUS_ERROR_EN (bus error on unmapped access
// after TIMEOUT cycles; otherwise unmapped accesses get a 0-wait open-bus ack).
module m68k_region_decoder #(
    parameter int unsigned NUM_REGIONS = 16,
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned WAIT_W      = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ADDR_W-1:0]             m68k_a,
    input  logic                          m68k_as_n,
    input  logic                          m68k_rw,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_mask,
    input  logic [NUM_REGIONS*WAIT_W-1:0] region_wait,
    input  logic [NUM_REGIONS*2-1:0]      region_dir,
    output logic [NUM_REGIONS-1:0]        cs,
    output logic [4:0]                    hit_idx,
    output logic                          hit,
    output logic                          dtack_n,
    output logic                          berr_n
);

    localparam int unsigned IDX_W = 5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_ACK    = 3'd3;
    localparam logic [2:0] ST_NOMAP  = 3'd4;

    localparam logic [1:0] DIR_ANY   = 2'b00;
    localparam logic [1:0] DIR_READ  = 2'b01;
    localparam logic [1:0] DIR_WRITE = 2'b10;

    // Elaboration-time parameter sanity checks
    if (NUM_REGIONS < 1 || NUM_REGIONS > 32) begin : g_bad_regions
        $error("m68k_region_decoder: NUM_REGIONS must be in 1..32");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("m68k_region_decoder: TIMEOUT must be at least 1");
    end

    // Per-region match: masked address compare qualified by direction
    logic [NUM_REGIONS-1:0] region_hit;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
        logic [ADDR_W-1:0] diff;
        logic [1:0]        dir;
        logic              dir_ok;

        assign diff   = (m68k_a ^ region_base[g*ADDR_W +: ADDR_W]) & region_mask[g*ADDR_W +: ADDR_W];
        assign dir    = region_dir[g*2 +: 2];
        assign dir_ok = (dir == DIR_ANY)
                      | ((dir == DIR_READ)  &  m68k_rw)
                      | ((dir == DIR_WRITE) & ~m68k_rw);
        assign region_hit[g] = (diff == '0) && dir_ok;
    end

    // Priority encoder: lowest matching index wins, its wait count travels along
    logic              match_any;
    logic [IDX_W-1:0]  match_idx;
    logic [WAIT_W-1:0] match_wait;

    always_comb begin
        match_any  = 1'b0;
        match_idx  = '0;
        match_wait = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (region_hit[i]) begin
                match_any  = 1'b1;
                match_idx  = IDX_W'(i);
                match_wait = region_wait[i*WAIT_W +: WAIT_W];
            end
        end
    end

    // Registered state
    logic [2:0]             state;
    logic                   armed;
    logic                   lat_valid;
    logic [IDX_W-1:0]       lat_idx;
    logic [WAIT_W-1:0]      lat_wait;
    logic [WAIT_W-1:0]      wcnt;

    // Next-state values
    logic [2:0]             state_d;
    logic                   armed_d;
    logic                   lat_valid_d;
    logic [IDX_W-1:0]       lat_idx_d;
    logic [WAIT_W-1:0]      lat_wait_d;
    logic [WAIT_W-1:0]      wcnt_d;
    logic [NUM_REGIONS-1:0] cs_d;
    logic [IDX_W-1:0]       hit_idx_d;
    logic                   hit_d;
    logic                   dtack_n_d;
    logic                   berr_n_d;

`ifdef M68K_BUS_ERROR_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] tcnt;
    logic [TO_W-1:0] tcnt_d;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        armed_d     = armed;
        lat_valid_d = lat_valid;
        lat_idx_d   = lat_idx;
        lat_wait_d  = lat_wait;
        wcnt_d      = wcnt;
        cs_d        = cs;
        hit_idx_d   = hit_idx;
        hit_d       = hit;
        dtack_n_d   = dtack_n;
        berr_n_d    = berr_n;
`ifdef M68K_BUS_ERROR_EN
        tcnt_d      = tcnt;
`endif

        case (state)
            ST_IDLE: begin
                cs_d      = '0;
                hit_idx_d = '0;
                hit_d     = 1'b0;
                dtack_n_d = 1'b1;
                berr_n_d  = 1'b1;
                wcnt_d    = '0;
                if (m68k_as_n) begin
                    // A strobe-high IDLE cycle is required before each access
                    armed_d = 1'b1;
                end else if (armed) begin
                    armed_d     = 1'b0;
                    lat_valid_d = match_any;
                    lat_idx_d   = match_idx;
                    lat_wait_d  = match_wait;
                    state_d     = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (m68k_as_n) begin
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                end else if (lat_valid) begin
                    cs_d      = NUM_REGIONS'(1) << lat_idx;
                    hit_d     = 1'b1;
                    hit_idx_d = lat_idx;
                    wcnt_d    = lat_wait;
                    state_d   = (lat_wait == '0) ? ST_ACK : ST_WAIT;
                end else begin
                    state_d = ST_NOMAP;
`ifdef M68K_BUS_ERROR_EN
                    tcnt_d  = '0;
`endif
                end
            end

            ST_WAIT: begin
                if (m68k_as_n) begin
                    state_d   = ST_IDLE;
                    cs_d      = '0;
                    hit_idx_d = '0;
                    hit_d     = 1'b0;
                    wcnt_d    = '0;
                end else if (wcnt == WAIT_W'(1)) begin
                    state_d = ST_ACK;
                end else begin
                    wcnt_d = wcnt - WAIT_W'(1);
                end
            end

            ST_ACK: begin
                if (m68k_as_n) begin
                    state_d   = ST_IDLE;
                    cs_d      = '0;
                    hit_idx_d = '0;
                    hit_d     = 1'b0;
                    dtack_n_d = 1'b1;
                    wcnt_d    = '0;
                end else begin
                    dtack_n_d = 1'b0;
                end
            end

            ST_NOMAP: begin
                if (m68k_as_n) begin
                    state_d   = ST_IDLE;
                    dtack_n_d = 1'b1;
                    berr_n_d  = 1'b1;
                end else begin
`ifdef M68K_BUS_ERROR_EN
                    // Count out the timeout, then hold bus error until release
                    if (tcnt == TO_W'(TIMEOUT)) begin
                        berr_n_d = 1'b0;
                    end else begin
                        tcnt_d = tcnt + TO_W'(1);
                    end
`else
                    // Open-bus acknowledge with no wait states
                    dtack_n_d = 1'b0;
`endif
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cs_d      = '0;
                hit_idx_d = '0;
                hit_d     = 1'b0;
                dtack_n_d = 1'b1;
                berr_n_d  = 1'b1;
                wcnt_d    = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            armed     <= 1'b0;
            lat_valid <= 1'b0;
            lat_idx   <= '0;
            lat_wait  <= '0;
            wcnt      <= '0;
            cs        <= '0;
            hit_idx   <= '0;
            hit       <= 1'b0;
            dtack_n   <= 1'b1;
            berr_n    <= 1'b1;
        end else begin
            state     <= state_d;
            armed     <= armed_d;
            lat_valid <= lat_valid_d;
            lat_idx   <= lat_idx_d;
            lat_wait  <= lat_wait_d;
            wcnt      <= wcnt_d;
            cs        <= cs_d;
            hit_idx   <= hit_idx_d;
            hit       <= hit_d;
            dtack_n   <= dtack_n_d;
            berr_n    <= berr_n_d;
        end
    end

`ifdef M68K_BUS_ERROR_EN
    // Unmapped-access timeout counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Directed, table-driven bench for m68k_region_decoder (default parameters).
// Expected values for unmapped accesses follow M68K_BUS_ERROR_EN if defined.
module tb_m68k_region_decoder;

    localparam int unsigned NR      = 16;
    localparam int unsigned AW      = 24;
    localparam int unsigned WW      = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam int          BOUND   = 100;

`ifdef M68K_BUS_ERROR_EN
    localparam int NM_DT = -1;
    localparam int NM_BE = 2 + TIMEOUT;
`else
    localparam int NM_DT = 2;
    localparam int NM_BE = -1;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic [AW-1:0]     m68k_a;
    logic              m68k_as_n;
    logic              m68k_rw;
    logic [NR*AW-1:0]  region_base;
    logic [NR*AW-1:0]  region_mask;
    logic [NR*WW-1:0]  region_wait;
    logic [NR*2-1:0]   region_dir;
    logic [NR-1:0]     cs;
    logic [4:0]        hit_idx;
    logic              hit;
    logic              dtack_n;
    logic              berr_n;

    int n_vec = 0;
    int n_err = 0;

    m68k_region_decoder #(
        .NUM_REGIONS (NR),
        .ADDR_W      (AW),
        .WAIT_W      (WW),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m68k_a      (m68k_a),
        .m68k_as_n   (m68k_as_n),
        .m68k_rw     (m68k_rw),
        .region_base (region_base),
        .region_mask (region_mask),
        .region_wait (region_wait),
        .region_dir  (region_dir),
        .cs          (cs),
        .hit_idx     (hit_idx),
        .hit         (hit),
        .dtack_n     (dtack_n),
        .berr_n      (berr_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;
        logic        rw;
        logic [15:0] cs;
        logic [4:0]  idx;
        logic        hit;
        int          dt;
        int          be;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_region(input int i, input logic [23:0] base, input logic [23:0] mask,
                              input logic [3:0] w, input logic [1:0] dir);
        region_base[i*AW +: AW] = base;
        region_mask[i*AW +: AW] = mask;
        region_wait[i*WW +: WW] = w;
        region_dir[i*2 +: 2]    = dir;
    endtask

    task automatic release_bus(input string name);
        m68k_as_n = 1'b1;
        tick();
        check({name, "_rel_cs"}, 32'(cs), 32'h0);
        check({name, "_rel_hit"}, 32'(hit), 32'h0);
        check({name, "_rel_dtack"}, 32'(dtack_n), 32'h1);
        check({name, "_rel_berr"}, 32'(berr_n), 32'h1);
        tick();
    endtask

    initial begin
        vecs[0]  = '{24'h012345, 1'b1, 16'h0001, 5'd0, 1'b1, 2,     -1};
        vecs[1]  = '{24'h073FFE, 1'b1, 16'h0002, 5'd1, 1'b1, 5,     -1};
        vecs[2]  = '{24'h074000, 1'b1, 16'h0000, 5'd0, 1'b0, NM_DT, NM_BE};
        vecs[3]  = '{24'h0E0002, 1'b1, 16'h0004, 5'd2, 1'b1, 3,     -1};
        vecs[4]  = '{24'h0F0000, 1'b0, 16'h0000, 5'd0, 1'b0, NM_DT, NM_BE};
        vecs[5]  = '{24'h0F0000, 1'b1, 16'h0008, 5'd3, 1'b1, 2,     -1};
        vecs[6]  = '{24'h100010, 1'b0, 16'h0010, 5'd4, 1'b1, 17,    -1};
        vecs[7]  = '{24'h100010, 1'b1, 16'h0000, 5'd0, 1'b0, NM_DT, NM_BE};
        vecs[8]  = '{24'h500000, 1'b1, 16'h0000, 5'd0, 1'b0, NM_DT, NM_BE};
        vecs[9]  = '{24'h200000, 1'b1, 16'h0000, 5'd0, 1'b0, NM_DT, NM_BE};
        vecs[10] = '{24'h03FFFF, 1'b0, 16'h0001, 5'd0, 1'b1, 2,     -1};
        vecs[11] = '{24'h040000, 1'b1, 16'h0000, 5'd0, 1'b0, NM_DT, NM_BE};

        reset_n     = 1'b0;
        m68k_as_n   = 1'b1;
        m68k_rw     = 1'b1;
        m68k_a      = '0;
        region_base = '0;
        region_mask = '0;
        region_wait = '0;
        region_dir  = {NR{2'b11}};
        set_region(0, 24'h000000, 24'hFC0000, 4'd0,  2'b00);
        set_region(1, 24'h070000, 24'hFFC000, 4'd3,  2'b00);
        set_region(2, 24'h0E0000, 24'hFFFF00, 4'd1,  2'b00);
        set_region(3, 24'h0F0000, 24'hFFFF00, 4'd0,  2'b01);
        set_region(4, 24'h100000, 24'hF00000, 4'd15, 2'b10);
        set_region(5, 24'h0E0000, 24'hFF0000, 4'd2,  2'b00);
        set_region(6, 24'h200000, 24'hF00000, 4'd0,  2'b11);

        tick();
        tick();
        check("rst_cs", 32'(cs), 32'h0);
        check("rst_hit", 32'(hit), 32'h0);
        check("rst_idx", 32'(hit_idx), 32'h0);
        check("rst_dtack", 32'(dtack_n), 32'h1);
        check("rst_berr", 32'(berr_n), 32'h1);
        reset_n = 1'b1;
        tick();

        // Table-driven accesses
        for (int v = 0; v < 12; v++) begin
            int dt;
            int be;
            string nm;
            nm = $sformatf("vec%0d", v);
            dt = -1;
            be = -1;
            m68k_a    = vecs[v].addr;
            m68k_rw   = vecs[v].rw;
            m68k_as_n = 1'b0;
            tick();
            for (int k = 1; k <= BOUND; k++) begin
                tick();
                if (k == 1) begin
                    check({nm, "_cs"}, 32'(cs), 32'(vecs[v].cs));
                    check({nm, "_hit"}, 32'(hit), 32'(vecs[v].hit));
                    check({nm, "_idx"}, 32'(hit_idx), 32'(vecs[v].idx));
                end
                if (dt < 0 && dtack_n == 1'b0) dt = k;
                if (be < 0 && berr_n == 1'b0) be = k;
                if (dt >= 0 || be >= 0) break;
            end
            check({nm, "_dtack_cycle"}, 32'(dt), 32'(vecs[v].dt));
            check({nm, "_berr_cycle"}, 32'(be), 32'(vecs[v].be));
            check({nm, "_cs_held"}, 32'(cs), 32'(vecs[v].cs));
            release_bus(nm);
        end

        // Early strobe release during WAIT: no dtack, outputs cleared
        begin
            int dcount;
            dcount = 0;
            m68k_a    = 24'h073FFE;
            m68k_rw   = 1'b1;
            m68k_as_n = 1'b0;
            tick();
            tick();
            check("early_cs1", 32'(cs), 32'h0002);
            tick();
            m68k_as_n = 1'b1;
            tick();
            check("early_cs", 32'(cs), 32'h0);
            check("early_hit", 32'(hit), 32'h0);
            for (int k = 0; k < 5; k++) begin
                if (dtack_n == 1'b0) dcount++;
                tick();
            end
            check("early_no_dtack", 32'(dcount), 32'h0);
        end

        // Reset during WAIT with strobe held low
        begin
            int bad;
            bad = 0;
            m68k_a    = 24'h100010;
            m68k_rw   = 1'b0;
            m68k_as_n = 1'b0;
            tick();
            tick();
            check("rstw_cs1", 32'(cs), 32'h0010);
            tick();
            tick();
            reset_n = 1'b0;
            tick();
            check("rstw_cs", 32'(cs), 32'h0);
            check("rstw_hit", 32'(hit), 32'h0);
            check("rstw_idx", 32'(hit_idx), 32'h0);
            check("rstw_dtack", 32'(dtack_n), 32'h1);
            check("rstw_berr", 32'(berr_n), 32'h1);
            reset_n = 1'b1;
            for (int k = 0; k < 25; k++) begin
                tick();
                if (hit == 1'b1 || dtack_n == 1'b0 || berr_n == 1'b0) bad++;
            end
            check("rstw_no_access", 32'(bad), 32'h0);
            m68k_as_n = 1'b1;
            tick();
            m68k_a    = 24'h012345;
            m68k_rw   = 1'b1;
            m68k_as_n = 1'b0;
            tick();
            tick();
            check("rstw_new_cs", 32'(cs), 32'h0001);
            tick();
            check("rstw_new_dtack", 32'(dtack_n), 32'h0);
            release_bus("rstw_new");
        end

        // Table changes after the latch edge do not affect the access
        begin
            int dt;
            dt = -1;
            m68k_a    = 24'h073FFE;
            m68k_rw   = 1'b1;
            m68k_as_n = 1'b0;
            tick();
            set_region(1, 24'h500000, 24'hFFC000, 4'd0, 2'b11);
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (k == 1) check("tbl_cs", 32'(cs), 32'h0002);
                if (dt < 0 && dtack_n == 1'b0) dt = k;
                if (dt >= 0) break;
            end
            check("tbl_dtack_cycle", 32'(dt), 32'd5);
            set_region(1, 24'h070000, 24'hFFC000, 4'd3, 2'b00);
            release_bus("tbl");
        end

        // Strobe high only during the release edge: no new access until re-armed
        begin
            int hits;
            hits = 0;
            m68k_a    = 24'h012345;
            m68k_rw   = 1'b1;
            m68k_as_n = 1'b0;
            tick();
            tick();
            tick();
            check("b2b_dtack", 32'(dtack_n), 32'h0);
            m68k_as_n = 1'b1;
            tick();
            m68k_as_n = 1'b0;
            for (int k = 0; k < 4; k++) begin
                tick();
                if (hit == 1'b1 || dtack_n == 1'b0) hits++;
            end
            check("b2b_blocked", 32'(hits), 32'h0);
            m68k_as_n = 1'b1;
            tick();
            m68k_as_n = 1'b0;
            tick();
            tick();
            check("b2b_rearm_cs", 32'(cs), 32'h0001);
            release_bus("b2b");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/m68k_region_decoder.md
Name: m68k_region_decoder

Overview:
- Parametrised, registered successor to the per-PCB combinational chip-select decoder.
- Decodes the 68000 address/strobe bus against a runtime-loaded table of NUM_REGIONS base/mask regions.
- Drives one-hot registered chip selects plus a DTACK generator with per-region wait states.
- Sits between the m68k core and the ROM/RAM/sprite/IO blocks; the table is driven per PCB by top level.

Parameters:
- NUM_REGIONS, 16, number of decode regions (1..32).
- ADDR_W, 24, decoded address width.
- WAIT_W, 4, width of per-region wait-state count.
- TIMEOUT, 64, cycles before bus error on an unmapped access (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- m68k_a  in  ADDR_W  byte address
- m68k_as_n  in  1  address strobe
- m68k_rw  in  1  1=read, 0=write
- region_base  in  NUM_REGIONS*ADDR_W  region i base at [i*ADDR_W +: ADDR_W]
- region_mask  in  NUM_REGIONS*ADDR_W  compare mask; a 1 bit is compared
- region_wait  in  NUM_REGIONS*WAIT_W  extra wait cycles per region
- region_dir  in  NUM_REGIONS*2  00 any, 01 read-only, 10 write-only, 11 disabled
- cs  out  NUM_REGIONS  one-hot registered chip selects
- hit_idx  out  5  index of the active region
- hit  out  1  an access is decoded and active
- dtack_n  out  1  data acknowledge to the 68000
- berr_n  out  1  bus error to the 68000

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE; cs=0, hit_idx=0, hit=0, dtack_n=1, berr_n=1, wait counter=0. Reset mid-access aborts it immediately; the next access is decoded only after m68k_as_n is seen high for at least one cycle.
- Region i matches when ((m68k_a ^ base_i) & mask_i)==0 and the dir permits m68k_rw. dir=11 never matches.
- Priority: the lowest matching index wins. cs carries at most one bit.
- FSM IDLE: on m68k_as_n==0 (cycle 0), latch the address, rw and priority-encode result, then go to DECODE.
- FSM DECODE (cycle 1): drive cs, hit=1, hit_idx; load the counter with region_wait[idx]. Go to ACK if wait==0, otherwise WAIT. With no match, go to NOMAP.
- FSM WAIT: decrement each cycle; go to ACK when the counter reaches 1. The first dtack_n=0 occurs at cycle 2+wait.
- FSM ACK: dtack_n=0, cs held. On m68k_as_n==1, go to IDLE, clearing cs/hit/dtack_n in that same edge.
- FSM NOMAP: see the optional feature.
- Early strobe release: m68k_as_n rising in DECODE or WAIT returns to IDLE and clears all outputs. No dtack is issued.
- The table is sampled only in IDLE. Changing inputs mid-access does not affect the current access.
- Back-to-back strobes: a new access requires one IDLE cycle with m68k_as_n==1.
- Counter width is WAIT_W. The maximum wait is 2^WAIT_W-1, with no wrap.

Optional Feature:
- Macro: M68K_BUS_ERROR_EN.
- Defined: NOMAP counts TIMEOUT cycles, then drives berr_n=0 (cs=0, dtack_n=1) until m68k_as_n rises, then returns to IDLE.
- Undefined: NOMAP behaves as a 0-wait open-bus ack. dtack_n=0 at cycle 2, cs=0, hit=0, and berr_n is held constant 1.

Test Plan:
- Region 0 base 000000 mask FC0000 wait 0; read 0x012345 → cs=0x0001 at cycle 1, dtack_n=0 at cycle 2, both clear one cycle after AS rises.
- Region 1 base 070000 mask FFC000 wait 3; read 0x073FFE → dtack_n=0 at cycle 5. Read 0x074000 → no region 1 hit.
- Overlap: regions 2 and 5 both match 0x0E0002 → cs=0x0004, hit_idx=2.
- Region 3 dir=01 at 0x0F0000; write → no match (NOMAP path). Read → cs bit 3.
- Unmapped 0x500000 with the macro defined and TIMEOUT=64 → berr_n=0 at cycle 66, dtack_n stays 1. Without the macro → dtack_n=0 at cycle 2, berr_n=1.
- reset_n=0 during WAIT → next edge all outputs at reset values. With AS still low, no new access until AS goes high then low.
